// File: rtl/my_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : my_serial_adder
// Purpose  : Bit-serial add/subtract engine. One full-adder cell is stepped
//            over a WIDTH-bit operand pair, LSB first, one bit per clock.
//            The carry is held in a flop between bits. Returns the sum, the
//            carry-out and the signed overflow flag.
// Ports    : clk, reset              - clock, async active-high reset
//            in_valid / in_ready     - request handshake (a, b, c, sub)
//            a, b                    - WIDTH-bit operands
//            c                       - carry-in (add) / borrow-in (sub)
//            sub                     - 0: a+b+c, 1: a-b-c
//            out_valid / out_ready   - result handshake
//            out_sum                 - WIDTH-bit result
//            out_carry               - carry-out (sub: 1 = no borrow)
//            out_overflow            - signed two's-complement overflow
// Revision : 1.0 - initial release
// ============================================================================
module my_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_cy;
    logic               r_carry;
    logic               r_ovf;

    logic               w_s;
    logic               w_co;
    logic               w_last;

    // Single full-adder cell operating on the current LSBs.
    assign w_s    = r_a[0] ^ r_b[0] ^ r_cy;
    assign w_co   = (r_a[0] & r_b[0]) | (r_a[0] & r_cy) | (r_b[0] & r_cy);
    assign w_last = (r_cnt == c_last_bit);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_next_state = ST_RUN;
            ST_RUN:  if (w_last)    w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default:                w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // Subtraction is performed as a + ~b + ~c: B is inverted at capture
    // and the initial carry is c ^ sub, so the same cell serves both.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_cy    <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b ^ {WIDTH{sub}};
                        r_cy  <= c ^ sub;
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum <= {w_s, r_sum[WIDTH-1:1]};
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_cy  <= w_co;
                    if (w_last) begin
                        // r_cy is the carry into the MSB here; overflow is
                        // its mismatch with the carry out of the MSB.
                        r_carry <= w_co;
                        r_ovf   <= r_cy ^ w_co;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (r_state == ST_IDLE);
    assign out_valid    = (r_state == ST_DONE);
    assign out_sum      = r_sum;
    assign out_carry    = r_carry;
    assign out_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_my_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_serial_adder
// Purpose  : Self-checking bench for my_serial_adder at WIDTH=16 and WIDTH=4.
//            Directed cases plus randomised operations against a reference
//            model computed with plain integer arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_my_serial_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic        sub;
    logic        sel;      // 0: WIDTH=16 instance, 1: WIDTH=4 instance

    logic        in_ready16, out_valid16, out_carry16, out_ovf16;
    logic [15:0] out_sum16;
    logic        in_ready4, out_valid4, out_carry4, out_ovf4;
    logic [3:0]  out_sum4;

    logic        w_in_ready, w_out_valid, w_out_carry, w_out_ovf;
    logic [15:0] w_out_sum;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    my_serial_adder #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid & ~sel),
        .in_ready     (in_ready16),
        .a            (a),
        .b            (b),
        .c            (c),
        .sub          (sub),
        .out_valid    (out_valid16),
        .out_ready    (out_ready & ~sel),
        .out_sum      (out_sum16),
        .out_carry    (out_carry16),
        .out_overflow (out_ovf16)
    );

    my_serial_adder #(.WIDTH(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid & sel),
        .in_ready     (in_ready4),
        .a            (a[3:0]),
        .b            (b[3:0]),
        .c            (c),
        .sub          (sub),
        .out_valid    (out_valid4),
        .out_ready    (out_ready & sel),
        .out_sum      (out_sum4),
        .out_carry    (out_carry4),
        .out_overflow (out_ovf4)
    );

    assign w_in_ready  = sel ? in_ready4  : in_ready16;
    assign w_out_valid = sel ? out_valid4 : out_valid16;
    assign w_out_carry = sel ? out_carry4 : out_carry16;
    assign w_out_ovf   = sel ? out_ovf4   : out_ovf16;
    assign w_out_sum   = sel ? {12'h000, out_sum4} : out_sum16;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the operand values.
    function automatic void model(input int w, input longint av, input longint bv,
                                  input int cv, input int sv,
                                  output longint es, output int ec, output int eo);
        longint mask, full, sa, sb, r, half;
        mask = (64'sd1 <<< w) - 1;
        half = 64'sd1 <<< (w - 1);
        av   = av & mask;
        bv   = bv & mask;
        sa   = (av >= half) ? av - (mask + 1) : av;
        sb   = (bv >= half) ? bv - (mask + 1) : bv;
        if (sv == 0) begin
            full = av + bv + cv;
            es   = full & mask;
            ec   = (full > mask) ? 1 : 0;
            r    = sa + sb + cv;
        end else begin
            full = av - bv - cv;
            es   = full & mask;
            ec   = (av >= bv + cv) ? 1 : 0;
            r    = sa - sb - cv;
        end
        eo = (r > half - 1 || r < -half) ? 1 : 0;
    endfunction

    // Present a request on the next negedge and hold until accepted.
    task automatic issue(input bit s, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic sv, input string tag);
        @(negedge clk);
        sel = s; a = av; b = bv; c = cv; sub = sv; in_valid = 1'b1;
        check({tag, "_in_ready_idle"}, 32'(w_in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); sub = 1'($urandom);
    endtask

    // Called on the negedge after the accept edge; counts edges to out_valid.
    task automatic wait_valid(input int exp_lat, input string tag);
        int cyc = 0;
        bit busy_ok = 1'b1;
        while (!w_out_valid && cyc < 40) begin
            if (w_in_ready) busy_ok = 1'b0;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_in_ready_busy"}, 32'(busy_ok), 32'd1);
    endtask

    task automatic check_res(input string tag, input longint es, input int ec, input int eo);
        check({tag, "_sum"},   32'(w_out_sum),   32'(es));
        check({tag, "_carry"}, 32'(w_out_carry), 32'(ec));
        check({tag, "_ovf"},   32'(w_out_ovf),   32'(eo));
    endtask

    task automatic consume(input int delay, input string tag);
        repeat (delay) begin
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_dropped"}, 32'(w_out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(w_in_ready), 32'd1);
    endtask

    task automatic do_op(input bit s, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic sv, input longint es, input int ec,
                         input int eo, input int delay, input string tag);
        issue(s, av, bv, cv, sv, tag);
        wait_valid(s ? 4 : 16, tag);
        check_res(tag, es, ec, eo);
        consume(delay, tag);
    endtask

    initial begin
        longint es;
        int     ec, eo;
        logic [15:0] av, bv;
        logic        cv, sv;
        bit          s;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c = 1'b0; sub = 1'b0; sel = 1'b0;
        #12;
        check("rst_in_ready",  32'(in_ready16),  32'd1);
        check("rst_out_valid", 32'(out_valid16), 32'd0);
        check("rst_sum",       32'(out_sum16),   32'd0);
        check("rst_carry",     32'(out_carry16), 32'd0);
        check("rst_ovf",       32'(out_ovf16),   32'd0);
        check("rst4_in_ready", 32'(in_ready4),   32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases, WIDTH=16
        do_op(0, 16'h1234, 16'h0101, 1, 0, 64'h1336, 0, 0, 0, "add_cin");
        do_op(0, 16'hFFFF, 16'h0001, 0, 0, 64'h0000, 1, 0, 1, "add_wrap");
        do_op(0, 16'h7FFF, 16'h0001, 0, 0, 64'h8000, 0, 1, 0, "add_ovf");
        do_op(0, 16'h0005, 16'h0007, 0, 1, 64'hFFFE, 0, 0, 0, "sub_neg");
        do_op(0, 16'h8000, 16'h0001, 0, 1, 64'h7FFF, 1, 1, 2, "sub_ovf");
        do_op(0, 16'h0010, 16'h0003, 1, 1, 64'h000C, 1, 0, 0, "sub_bin");

        // Backpressure with a waiting request and changing operands
        issue(0, 16'h1111, 16'h2222, 0, 0, "bp");
        wait_valid(16, "bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_valid", 32'(w_out_valid), 32'd1);
            check("bp_hold_ready", 32'(w_in_ready),  32'd0);
            check("bp_hold_sum",   32'(w_out_sum),   32'h3333);
            check("bp_hold_carry", 32'(w_out_carry), 32'd0);
        end
        a = 16'h4000; b = 16'h0123; c = 1'b1; sub = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_in_ready_rise", 32'(w_in_ready), 32'd1);
        @(posedge clk);               // in_valid still high: accepted here
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(16, "bp_next");
        check_res("bp_next", 64'h3EDC, 1, 0);
        consume(0, "bp_next");

        // Reset during RUN: abort before the 7th RUN edge
        issue(0, 16'hAAAA, 16'h5555, 0, 0, "rst_mid");
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_in_ready",  32'(in_ready16),  32'd1);
        check("rst_mid_out_valid", 32'(out_valid16), 32'd0);
        check("rst_mid_sum",       32'(out_sum16),   32'd0);
        check("rst_mid_carry",     32'(out_carry16), 32'd0);
        check("rst_mid_ovf",       32'(out_ovf16),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            bit seen = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (out_valid16) seen = 1'b1;
            end
            check("rst_mid_no_pulse", 32'(seen), 32'd0);
        end
        do_op(0, 16'h00FF, 16'h0001, 0, 0, 64'h0100, 0, 0, 0, "post_rst");

        // WIDTH=4 directed
        do_op(1, 16'h000F, 16'h0001, 0, 0, 64'h0, 1, 0, 0, "w4_wrap");

        // Randomised operations on both widths
        for (int i = 0; i < 1000; i++) begin
            s  = 1'(i % 2);
            av = 16'($urandom);
            bv = 16'($urandom);
            cv = 1'($urandom);
            sv = 1'($urandom);
            model(s ? 4 : 16, longint'(av), longint'(bv), int'(cv), int'(sv), es, ec, eo);
            do_op(s, av, bv, cv, sv, es, ec, eo, $urandom_range(0, 2),
                  s ? "rand4" : "rand16");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
